// File: rtl/add_acc_pipe.sv
// rtl/add_acc_pipe.sv - pipelined pairwise adder / burst accumulator with valid-ready handshake
//
// Purpose:
//   Mode 0 adds i_a + i_b and presents the sum one cycle after acceptance.
//   Mode 1 accumulates acc + i_a + i_b over a burst and presents the total
//   one cycle after the beat flagged i_last. While a burst is open, i_mode is
//   ignored. o_ovf reports whether any sum that contributed to the reported
//   result exceeded 2^BW_DATA-1.
//
// Configuration:
//   ADD_ACC_SAT_EN - when defined, acc and o_y saturate to all-ones on
//                    overflow; otherwise they wrap modulo 2^BW_DATA.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - synchronous active-high reset
//   i_valid  - input beat valid
//   o_ready  - block can accept an input beat
//   i_a/i_b  - unsigned operands, BW_DATA bits
//   i_mode   - 0 = pairwise add, 1 = accumulate burst
//   i_last   - final beat of an accumulate burst
//   o_valid  - result valid
//   i_ready  - downstream accepts result
//   o_y      - result, BW_DATA bits
//   o_ovf    - result overflow flag

module add_acc_pipe #(
    parameter int BW_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_DATA-1:0] i_b,
    input  logic               i_mode,
    input  logic               i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_y,
    output logic               o_ovf
);

    localparam int W_SUM = BW_DATA + 2;

    logic [BW_DATA-1:0] acc;
    logic               ovf_flag;
    logic               burst_open;

    logic               accept;
    logic               in_burst;
    logic               ends_result;
    logic [BW_DATA-1:0] acc_in;
    logic [W_SUM-1:0]   sum;
    logic               ovf_now;
    logic               ovf_tot;
    logic [BW_DATA-1:0] res;

    // Output register frees up in the same cycle it is drained: no bubble.
    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    always_comb begin
        in_burst    = burst_open || i_mode;
        // A beat produces a result in mode 0, or when it closes a burst.
        ends_result = !in_burst || i_last;
        // acc is only meaningful inside an open burst; a new burst or a
        // mode-0 beat starts from zero.
        acc_in      = burst_open ? acc : '0;
        sum         = W_SUM'(acc_in) + W_SUM'(i_a) + W_SUM'(i_b);
        ovf_now     = |sum[W_SUM-1:BW_DATA];
        ovf_tot     = (burst_open && ovf_flag) || ovf_now;
`ifdef ADD_ACC_SAT_EN
        // Once saturated, the burst stays pinned at all-ones.
        res         = ovf_tot ? '1 : sum[BW_DATA-1:0];
`else
        res         = sum[BW_DATA-1:0];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_y        <= '0;
            o_ovf      <= 1'b0;
            acc        <= '0;
            ovf_flag   <= 1'b0;
            burst_open <= 1'b0;
        end else if (accept) begin
            if (ends_result) begin
                o_valid    <= 1'b1;
                o_y        <= res;
                o_ovf      <= ovf_tot;
                acc        <= '0;
                ovf_flag   <= 1'b0;
                burst_open <= 1'b0;
            end else begin
                // Accepting implies any pending result was drained this edge.
                o_valid    <= 1'b0;
                acc        <= res;
                ovf_flag   <= ovf_tot;
                burst_open <= 1'b1;
            end
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: doc/add_acc_pipe.md
ADD_ACC_PIPE -- requirements
Module: add_acc_pipe

Interface
REQ-001 SHALL have parameter BW_DATA, default 8: width of operands, accumulator and result.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1 bit: input beat valid.
REQ-005 SHALL have port o_ready, output, 1 bit: block can accept an input beat.
REQ-006 SHALL have ports i_a and i_b, input, BW_DATA bits each: unsigned operands.
REQ-007 SHALL have port i_mode, input, 1 bit: 0 = pairwise add, 1 = accumulate burst.
REQ-008 SHALL have port i_last, input, 1 bit: final beat of an accumulate burst; ignored in mode 0.
REQ-009 SHALL have port o_valid, output, 1 bit: result valid.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream accepts result.
REQ-011 SHALL have port o_y, output, BW_DATA bits: result.
REQ-012 SHALL have port o_ovf, output, 1 bit: result exceeded 2^BW_DATA-1.

Function
REQ-013 SHALL accept a beat exactly when i_valid && o_ready at a rising edge.
REQ-014 SHALL drive o_ready = !o_valid || i_ready (combinational), so there is no bubble under continuous flow.
REQ-015 SHALL hold o_y/o_ovf stable while o_valid && !i_ready; SHALL clear o_valid on a handshake with no new result.
REQ-016 SHALL compute each beat sum internally at BW_DATA+2 bits (acc + a + b) with no truncation before the overflow check.
REQ-017 Mode 0 SHALL present o_y = i_a + i_b with o_valid=1 the cycle after acceptance (latency 1).
REQ-018 Mode 1 SHALL hold a BW_DATA-bit accumulator plus a sticky burst-overflow flag; each accepted beat with i_last=0 SHALL update acc <= acc+a+b and produce no output.
REQ-019 Mode 1 SHALL, on an accepted beat with i_last=1, present acc+a+b on o_y with o_valid=1 the next cycle, then clear acc and the overflow flag to 0.
REQ-020 A burst SHALL be open from its first accepted mode-1 beat until its i_last beat; while it is open, i_mode SHALL be ignored and every beat SHALL be treated as mode 1.
REQ-021 o_ovf SHALL be 1 if any intermediate or final sum of the reported result exceeded 2^BW_DATA-1.
REQ-022 A mode-1 single-beat burst (i_last=1 on its first beat) SHALL behave identically to mode 0.

Reset
REQ-023 i_rst=1 SHALL, at the next rising edge, set o_valid=0, o_y=0, o_ovf=0, acc=0, the overflow flag to 0 and the burst-open flag to 0, overriding any concurrent handshake.
REQ-024 A burst or result in flight at reset SHALL be discarded with no output.
REQ-025 o_ready SHALL be 1 in the cycle after reset is released.

Configuration
REQ-026 Macro ADD_ACC_SAT_EN defined: on overflow, acc and o_y SHALL saturate to all-ones, and subsequent beats of the same burst SHALL leave acc at all-ones.
REQ-027 ADD_ACC_SAT_EN undefined: acc and o_y SHALL wrap modulo 2^BW_DATA; o_ovf SHALL still be reported per REQ-021.

Verification (BW_DATA=4)
REQ-028 Mode 0, a=3, b=4, i_ready=1 -> next cycle o_valid=1, o_y=7, o_ovf=0.
REQ-029 Mode 0, a=15, b=15 -> o_ovf=1; o_y=14 without the macro, o_y=15 with it.
REQ-030 Mode 1, beats (1,2), (3,4), (5,0,last) -> exactly one result, o_y=15, o_ovf=0, one cycle after the last beat.
REQ-031 Result pending with i_ready=0 for 3 cycles -> o_ready=0 and o_y held; i_ready=1 with i_valid=1 -> new beat accepted in the same cycle.
REQ-032 Mode 1 beat (7,7), then i_rst=1 for one cycle, then mode-1 beat (1,1,last) -> o_y=2, o_ovf=0, and no output for the discarded burst.
REQ-033 Burst open, next beat (2,2) with i_mode=0 and i_last=0 -> no output; the following beat (0,0,last) -> o_y equals the burst total.
